// File: rtl/rgmii_cal_pkg.sv
// rtl/rgmii_cal_pkg.sv - shared types and widths for the RGMII IDELAY tap calibrator
package rgmii_cal_pkg;

    localparam int TAP_W   = 5;
    localparam int TAP_MAX = 31;
    localparam int LEN_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_TAP,
        ST_SETTLE,
        ST_MEASURE,
        ST_JUDGE,
        ST_CENTER,
        ST_DONE,
        ST_FAIL
    } cal_state_t;

endpackage

// File: rtl/rgmii_cal_window.sv
// rtl/rgmii_cal_window.sv - run/best passing-window tracker and centre-tap computation
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   clear        restart tracking (start of a calibration)
//   judge        one-cycle strobe: score the current tap
//   pass         verdict for the current tap, sampled with judge
//   tap          tap being judged
//   best_start   first tap of the longest passing window so far
//   best_len     length of that window
//   centre       best_start + (best_len-1)/2
module rgmii_cal_window
    import rgmii_cal_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             judge,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len,
    output logic [TAP_W-1:0] centre
);

    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;
    logic [TAP_W-1:0] cur_start;
    logic [LEN_W-1:0] cur_len;

    always_comb begin
        cur_start = (run_len == '0) ? tap : run_start;
        cur_len   = run_len + LEN_W'(1);
        // Only meaningful when best_len >= 1; the caller gates on a minimum length.
        centre    = TAP_W'({1'b0, best_start} + ((best_len - LEN_W'(1)) >> 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (judge) begin
            if (pass) begin
                run_start <= cur_start;
                run_len   <= cur_len;
                // Strictly greater: an equal-length later window never displaces the earlier one.
                if (cur_len > best_len) begin
                    best_start <= cur_start;
                    best_len   <= cur_len;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/rgmii_idelay_cal.sv
// rtl/rgmii_idelay_cal.sv - IDELAY tap sweep calibrator driving the RGMII data-lane delay setting
//
// Ports:
//   delay_clk, delay_rst_n  control clock and synchronous active-low reset
//   cal_start               single-cycle calibration request (ignored while busy)
//   byte_vld, byte_ok       pattern-checker strobe and match flag
//   delay_set_out           tap readback from the IDELAY
//   delay_set_in            tap loaded into the IDELAY
//   cal_busy                sweep in progress
//   cal_done, cal_fail      sticky result of the last calibration
//   win_start, win_len      best passing window found by the last calibration
module rgmii_idelay_cal
    import rgmii_cal_pkg::*;
#(
    parameter int               SETTLE_CYC  = 16,
    parameter int               MEAS_BYTES  = 64,
    parameter int               TIMEOUT_CYC = 4096,
    parameter int               MIN_WIN     = 4,
    parameter logic [TAP_W-1:0] DEFAULT_TAP = 5'd0
) (
    input  logic             delay_clk,
    input  logic             delay_rst_n,
    input  logic             cal_start,
    input  logic             byte_vld,
    input  logic             byte_ok,
    input  logic [TAP_W-1:0] delay_set_out,
    output logic [TAP_W-1:0] delay_set_in,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [TAP_W-1:0] win_start,
    output logic [LEN_W-1:0] win_len
);

    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int BYTE_W = $clog2(MEAS_BYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    cal_state_t        state;
    cal_state_t        next_state;
    logic [SET_W-1:0]  settle_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [TAP_W-1:0]  tap;
    logic              tap_bad;

    logic              start_ok;
    logic              settle_last;
    logic              timeout_hit;
    logic              byte_last;

    logic [TAP_W-1:0]  best_start;
    logic [LEN_W-1:0]  best_len;
    logic [TAP_W-1:0]  centre;

    rgmii_cal_window u_window (
        .clk        (delay_clk),
        .resetn     (delay_rst_n),
        .clear      (start_ok),
        .judge      (state == ST_JUDGE),
        .pass       (!tap_bad),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len),
        .centre     (centre)
    );

    always_comb begin
        start_ok    = cal_start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
        settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));
        timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        byte_last   = byte_vld && (byte_cnt == BYTE_W'(MEAS_BYTES - 1));

        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: if (start_ok) next_state = ST_SET_TAP;
            ST_SET_TAP:                next_state = ST_SETTLE;
            ST_SETTLE:                 if (settle_last) next_state = ST_MEASURE;
            ST_MEASURE:                if (timeout_hit || byte_last) next_state = ST_JUDGE;
            ST_JUDGE:                  next_state = (tap == TAP_W'(TAP_MAX)) ? ST_CENTER : ST_SET_TAP;
            ST_CENTER:                 next_state = (best_len >= LEN_W'(MIN_WIN)) ? ST_DONE : ST_FAIL;
            default:                   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge delay_clk) begin
        if (!delay_rst_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            tap          <= '0;
            tap_bad      <= 1'b0;
            delay_set_in <= DEFAULT_TAP;
            cal_busy     <= 1'b0;
            cal_done     <= 1'b0;
            cal_fail     <= 1'b0;
            win_start    <= '0;
            win_len      <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_ok) begin
                        tap      <= '0;
                        cal_busy <= 1'b1;
                        cal_done <= 1'b0;
                        cal_fail <= 1'b0;
                    end
                end
                ST_SET_TAP: begin
                    delay_set_in <= tap;
                    settle_cnt   <= '0;
                    tap_bad      <= 1'b0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (settle_last) begin
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        if (delay_set_out != tap) tap_bad <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // Timeout takes precedence: a strobe on the timeout cycle is not scored.
                    if (timeout_hit) begin
                        tap_bad <= 1'b1;
                    end else if (byte_vld) begin
                        byte_cnt <= byte_cnt + BYTE_W'(1);
                        if (!byte_ok) tap_bad <= 1'b1;
                    end
                end
                ST_JUDGE: begin
                    tap <= tap + TAP_W'(1);
                end
                ST_CENTER: begin
                    win_start <= best_start;
                    win_len   <= best_len;
                    cal_busy  <= 1'b0;
                    if (best_len >= LEN_W'(MIN_WIN)) begin
                        delay_set_in <= centre;
                        cal_done     <= 1'b1;
                    end else begin
                        delay_set_in <= DEFAULT_TAP;
                        cal_fail     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_idelay_cal.sv
// tb/tb_rgmii_idelay_cal.sv - self-checking bench for rgmii_idelay_cal
module tb_rgmii_idelay_cal;

    localparam int         SETTLE_CYC  = 4;
    localparam int         MEAS_BYTES  = 8;
    localparam int         TIMEOUT_CYC = 64;
    localparam int         MIN_WIN     = 4;
    localparam logic [4:0] DEFAULT_TAP = 5'd7;
    localparam int         LIMIT       = 5000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cal_start;
    logic       byte_vld;
    logic       byte_ok;
    logic [4:0] delay_set_out;
    logic [4:0] delay_set_in;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [4:0] win_start;
    logic [5:0] win_len;

    // Stimulus controls: which taps produce good bytes, whether strobes occur, readback fault.
    logic [31:0] pass_mask = '0;
    logic        strobe_en = 1'b1;
    logic        force_en  = 1'b0;
    logic [4:0]  force_tap = '0;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rgmii_idelay_cal #(
        .SETTLE_CYC  (SETTLE_CYC),
        .MEAS_BYTES  (MEAS_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MIN_WIN     (MIN_WIN),
        .DEFAULT_TAP (DEFAULT_TAP)
    ) dut (
        .delay_clk     (clk),
        .delay_rst_n   (rst_n),
        .cal_start     (cal_start),
        .byte_vld      (byte_vld),
        .byte_ok       (byte_ok),
        .delay_set_out (delay_set_out),
        .delay_set_in  (delay_set_in),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done),
        .cal_fail      (cal_fail),
        .win_start     (win_start),
        .win_len       (win_len)
    );

    // IDELAY readback model: echoes the loaded tap unless a stuck-at-zero fault is injected.
    assign delay_set_out = (force_en && delay_set_in == force_tap) ? 5'd0 : delay_set_in;

    // Pattern checker model: random strobes, bytes good only at taps in pass_mask.
    initial begin
        byte_vld = 1'b0;
        byte_ok  = 1'b0;
        forever begin
            @(negedge clk);
            byte_vld = strobe_en && ($urandom_range(3) != 0);
            byte_ok  = (delay_set_in === 5'bxxxxx) ? 1'b0 : pass_mask[delay_set_in];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: longest run of good taps (earliest on ties), centre, and verdict.
    task automatic model(input logic [31:0] good, output int ws, output int wl,
                         output int dsi, output int dn, output int fl);
        int run_s = 0;
        int run_l = 0;
        ws = 0;
        wl = 0;
        for (int t = 0; t < 32; t++) begin
            if (good[t]) begin
                if (run_l == 0) run_s = t;
                run_l++;
                if (run_l > wl) begin
                    wl = run_l;
                    ws = run_s;
                end
            end else begin
                run_l = 0;
            end
        end
        dn  = (wl >= MIN_WIN) ? 1 : 0;
        fl  = 1 - dn;
        dsi = dn ? ws + (wl - 1) / 2 : int'(DEFAULT_TAP);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(cal_busy), 32'd0);
        check({tag, "_dsi"}, 32'(delay_set_in), 32'(DEFAULT_TAP));
        check({tag, "_done"}, 32'(cal_done), 32'd0);
        check({tag, "_fail"}, 32'(cal_fail), 32'd0);
        check({tag, "_wstart"}, 32'(win_start), 32'd0);
        check({tag, "_wlen"}, 32'(win_len), 32'd0);
    endtask

    // Pulse cal_start; busy must be up one edge later and tap 0 loaded the edge after.
    task automatic pulse_start(input string tag);
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1;
        cal_start = 1'b0;
        check({tag, "_start_busy"}, 32'(cal_busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_start_tap0"}, 32'(delay_set_in), 32'd0);
    endtask

    // Returns the number of cycles cal_busy was seen high (including the two in pulse_start).
    task automatic wait_idle(input string tag, output int cyc);
        cyc = 2;
        while (cal_busy && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            if (cal_busy) cyc++;
        end
        check({tag, "_ends"}, 32'(cal_busy), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] good);
        int ws, wl, dsi, dn, fl;
        model(good, ws, wl, dsi, dn, fl);
        check({tag, "_wstart"}, 32'(win_start), 32'(ws));
        check({tag, "_wlen"}, 32'(win_len), 32'(wl));
        check({tag, "_dsi"}, 32'(delay_set_in), 32'(dsi));
        check({tag, "_done"}, 32'(cal_done), 32'(dn));
        check({tag, "_fail"}, 32'(cal_fail), 32'(fl));
    endtask

    task automatic run_cal(input string tag, input logic [31:0] mask);
        int cyc;
        logic [31:0] good;
        pass_mask = mask;
        good = mask;
        if (force_en && force_tap != 5'd0) good[force_tap] = 1'b0;
        pulse_start(tag);
        wait_idle(tag, cyc);
        check_result(tag, good);
    endtask

    function automatic logic [31:0] range_mask(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    initial begin
        int cyc;
        int n;
        logic [31:0] m;
        cal_start = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_cal("win8_19", range_mask(8, 19));
        run_cal("tie", range_mask(2, 5) | range_mask(20, 23));
        run_cal("all", 32'hFFFF_FFFF);
        run_cal("top2", range_mask(30, 31));

        for (int i = 0; i < 3; i++) begin
            int lo = $urandom_range(0, 27);
            int hi = $urandom_range(lo + 3, 31);
            m = range_mask(lo, hi) | ($urandom() & $urandom());
            run_cal($sformatf("rand%0d", i), m);
        end

        // No strobes at all: every tap times out.  Busy covers 32 full tap slots plus the CENTER cycle.
        strobe_en = 1'b0;
        pass_mask = 32'hFFFF_FFFF;
        pulse_start("timeout");
        wait_idle("timeout", cyc);
        check("timeout_cycles", 32'(cyc), 32'(32 * (SETTLE_CYC + TIMEOUT_CYC + 2) + 1));
        check_result("timeout", 32'd0);
        strobe_en = 1'b1;

        // Readback stuck at 0 while tap 10 is loaded.
        force_en  = 1'b1;
        force_tap = 5'd10;
        run_cal("rdbk10", range_mask(6, 14));
        force_en  = 1'b0;

        // Reset in the middle of tap 17: outputs (including stale window) go back to reset values.
        pass_mask = range_mask(3, 12);
        pulse_start("mid_rst");
        n = 0;
        while (delay_set_in !== 5'd17 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_rst_reach17", 32'(delay_set_in), 32'd17);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh calibration with a redundant cal_start at tap 20 that must not restart the sweep.
        pass_mask = range_mask(9, 25);
        pulse_start("restart");
        n = 0;
        while (delay_set_in !== 5'd20 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("restart_reach20", 32'(delay_set_in), 32'd20);
        @(negedge clk);
        cal_start = 1'b1;
        @(posedge clk);
        #1;
        cal_start = 1'b0;
        n = 0;
        while (delay_set_in === 5'd20 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_start_ignored", 32'(delay_set_in), 32'd21);
        wait_idle("restart", cyc);
        check_result("restart", range_mask(9, 25));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
